// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// Requester A is ALU writeback (rd), B is load writeback (rt).
module regfile_wport_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          hold,
    output logic          mux_sel,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [CW-1:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_t;

    state_t        state;
    logic          ptr_q;
    logic          ptr;
    logic          grant_a;
    logic          grant_b;
    logic          grant;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;

    // Pointer 0 favours A, 1 favours B; a grant last cycle flips it
    // to the other requester, an idle cycle keeps the saved value.
    always_comb begin
        ptr = ptr_q;
        case (state)
            WR_A:    ptr = 1'b1;
            WR_B:    ptr = 1'b0;
            default: ptr = ptr_q;
        endcase
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && !hold) begin
            grant_a = a_valid && (!b_valid || !ptr);
            grant_b = b_valid && (!a_valid || ptr);
        end
    end

    assign grant   = grant_a || grant_b;
    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign g_addr  = grant_b ? b_addr : a_addr;
    assign g_data  = grant_b ? b_data : a_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr_q    <= 1'b0;
            mux_sel  <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wr_count <= '0;
        end else begin
            ptr_q <= ptr;
            if (grant_a) begin
                state <= WR_A;
            end else if (grant_b) begin
                state <= WR_B;
            end else begin
                state <= IDLE;
            end
            if (grant) begin
                mux_sel  <= grant_b;
                rf_waddr <= g_addr;
                rf_wdata <= g_data;
                // $zero writes are accepted and counted but never strobed
                rf_we    <= |g_addr;
                wr_count <= wr_count + CW'(1);
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: vector table plus
// hand-written reset, async-reset and counter-wrap sequences.
module tb_regfile_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        hold;
    logic        mux_sel;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  wr_count;

    int total = 0;
    int bad = 0;

    regfile_wport_arbiter #(.DW(32), .AW(5), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .hold     (hold),
        .mux_sel  (mux_sel),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        hd;
        logic        ear;
        logic        ebr;
        logic        ewe;
        logic        esel;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa,
                         input logic [31:0] ad, input logic bv,
                         input logic [4:0] ba, input logic [31:0] bd,
                         input logic hd);
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        hold    = hd;
    endtask

    task automatic chk_regs(input string tag, input logic we,
                            input logic sel, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [3:0] cnt);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, ".mux_sel"}, 32'(mux_sel), 32'(sel));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
        chk({tag, ".rf_wdata"}, rf_wdata, wd);
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(cnt));
    endtask

    localparam logic [31:0] DA = 32'hAAAA_0003;
    localparam logic [31:0] DB = 32'hBBBB_0007;

    initial begin
        tbl[0]  = '{1, 5, 32'h1234, 0, 0, 0, 0,  1, 0, 1, 0, 5, 32'h1234, 1};
        tbl[1]  = '{0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0,
                    0, 1, 0, 1, 0, 32'hFFFF_FFFF, 2};
        tbl[2]  = '{1, 3, DA, 1, 7, DB, 0,  1, 0, 1, 0, 3, DA, 3};
        tbl[3]  = '{1, 3, DA, 1, 7, DB, 0,  0, 1, 1, 1, 7, DB, 4};
        tbl[4]  = '{1, 3, DA, 1, 7, DB, 0,  1, 0, 1, 0, 3, DA, 5};
        tbl[5]  = '{1, 3, DA, 1, 7, DB, 0,  0, 1, 1, 1, 7, DB, 6};
        tbl[6]  = '{0, 3, DA, 0, 7, DB, 0,  0, 0, 0, 1, 7, DB, 6};
        tbl[7]  = '{1, 3, DA, 1, 7, DB, 1,  0, 0, 0, 1, 7, DB, 6};
        tbl[8]  = '{1, 3, DA, 1, 7, DB, 1,  0, 0, 0, 1, 7, DB, 6};
        tbl[9]  = '{1, 3, DA, 1, 7, DB, 1,  0, 0, 0, 1, 7, DB, 6};
        tbl[10] = '{1, 3, DA, 1, 7, DB, 0,  1, 0, 1, 0, 3, DA, 7};
        tbl[11] = '{1, 3, DA, 1, 7, DB, 0,  0, 1, 1, 1, 7, DB, 8};
        tbl[12] = '{0, 3, DA, 1, 31, 32'h1F, 0,
                    0, 1, 1, 1, 31, 32'h1F, 9};
        tbl[13] = '{1, 0, 32'h55, 0, 7, DB, 0,
                    1, 0, 0, 0, 0, 32'h55, 10};
        tbl[14] = '{1, 3, DA, 1, 7, DB, 0,  0, 1, 1, 1, 7, DB, 11};

        // reset state with random payloads, nothing valid
        rst = 1'b1;
        drive(0, 5'($urandom), $urandom, 0, 5'($urandom), $urandom, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a_ready", 32'(a_ready), 0);
        chk("rst.b_ready", 32'(b_ready), 0);
        chk_regs("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad,
                  tbl[i].bv, tbl[i].ba, tbl[i].bd, tbl[i].hd);
            @(negedge clk);
            chk($sformatf("v%0d.a_ready", i), 32'(a_ready), 32'(tbl[i].ear));
            chk($sformatf("v%0d.b_ready", i), 32'(b_ready), 32'(tbl[i].ebr));
            @(posedge clk);
            #1;
            chk_regs($sformatf("v%0d", i), tbl[i].ewe, tbl[i].esel,
                     tbl[i].ewa, tbl[i].ewd, tbl[i].ecnt);
        end

        // stream A writes, then hit reset between edges
        for (int i = 0; i < 3; i++) begin
            drive(1, 9, 32'h900 + 32'(i), 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        chk_regs("stream", 1, 0, 9, 32'h902, 14);
        #2;
        rst = 1'b1;
        #1;
        chk_regs("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 3, DA, 1, 7, DB, 0);
        #1;
        chk("post_rst.a_ready", 32'(a_ready), 1);
        chk("post_rst.b_ready", 32'(b_ready), 0);
        @(posedge clk);
        #1;
        chk_regs("post_rst", 1, 0, 3, DA, 1);

        // counter wrap with a 4-bit counter
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 17; i++) begin
            drive(1, 1, 32'(i), 0, 0, 0, 0);
            @(posedge clk);
            #1;
            if (i == 15) chk("wrap15", 32'(wr_count), 15);
            if (i == 16) chk("wrap16", 32'(wr_count), 0);
            if (i == 17) chk("wrap17", 32'(wr_count), 1);
        end
        chk("wrap.rf_wdata", rf_wdata, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port between two requesters: A (ALU/R-type writeback, rd field) and B (load/I-type writeback, rt field).
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the select of the 5-bit and 32-bit 2:1 write-address/data muxes, plus a registered write strobe.
- Sits between the writeback stage and the register file; one write per clock maximum.

Parameters:
- DW, 32, write-data width.
- AW, 5, register address width.
- CW, 16, width of the accepted-write statistics counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  AW  requester A destination register.
- a_data  in  DW  requester A write data.
- a_ready  out  1  A accepted this cycle (combinational).
- b_valid  in  1  requester B has a write pending.
- b_addr  in  AW  requester B destination register.
- b_data  in  DW  requester B write data.
- b_ready  out  1  B accepted this cycle (combinational).
- hold  in  1  register file busy; no grants while high.
- mux_sel  out  1  registered select: 0 = A path, 1 = B path.
- rf_we  out  1  registered write enable to the register file.
- rf_waddr  out  AW  registered write address.
- rf_wdata  out  DW  registered write data.
- wr_count  out  CW  number of accepted requests, wraps modulo 2^CW.

Behaviour:
- Reset values (asynchronous, immediate): mux_sel=0, rf_we=0, rf_waddr=0, rf_wdata=0, wr_count=0, state=IDLE, priority pointer=A.
- States (encode the last cycle's grant):
  - IDLE: nothing granted.
  - WR_A: A granted.
  - WR_B: B granted.
- Grant logic (combinational, within the same cycle):
  - hold=1: a_ready=b_ready=0.
  - Otherwise, only one requester valid: that requester gets ready=1.
  - Otherwise, both valid: the requester indicated by the priority pointer wins; the loser sees ready=0 and must hold valid/addr/data stable.
  - Neither valid: both ready=0.
- Pointer update: after a grant to X, the pointer moves to the other requester. No grant: the pointer is unchanged.
- Transitions at each clock edge:
  - Any state -> WR_A on an A grant; -> WR_B on a B grant; -> IDLE when there is no grant.
- Output register, latency 1: a handshake in cycle N produces its outputs in cycle N+1.
  - mux_sel = grantee (A=0, B=1).
  - rf_waddr and rf_wdata = the grantee's addr and data.
  - rf_we = 1, except when the grantee's addr is 0: register $zero writes are accepted (ready=1) and counted, but rf_we=0.
- No grant in cycle N:
  - rf_we=0 in cycle N+1.
  - mux_sel, rf_waddr and rf_wdata hold their previous values.
- wr_count increments by 1 per accepted handshake, including addr-0 writes. It wraps from all-ones to 0 silently.
- hold asserted with both requesters valid: no grant and no pointer change. The first cycle after hold drops grants according to the retained pointer.
- Requester drops valid before ready: no grant, no side effect (legal but discouraged).
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight write is lost (rf_we=0 at once).
- Sequencing on release: the first edge after rst deasserts is a normal arbitration edge with the pointer at A.
- Sustained throughput: back-to-back grants every cycle. With both requesters continuously valid, the grant sequence is A,B,A,B... starting from the current pointer.

Test Plan:
- Reset check: rst=1 with random inputs -> all outputs 0 and a_ready=b_ready=0 (while hold=0, no valid). Release, then a_valid=1, a_addr=5, a_data=0x1234 -> a_ready=1 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, mux_sel=0, wr_count=1.
- Fairness: a_valid=b_valid=1 held for 4 cycles (A addr 3, B addr 7) -> grants A,B,A,B; rf_waddr sequence 3,7,3,7; mux_sel 0,1,0,1; wr_count=4.
- Zero register: b_valid=1, b_addr=0, b_data=0xFFFFFFFF -> b_ready=1; next cycle rf_we=0, wr_count incremented, pointer moves to A.
- Hold: both valid, hold=1 for 3 cycles -> no ready, rf_we=0, wr_count unchanged. Release hold -> the pointer-favoured requester is granted first.
- Mid-operation reset: stream A writes, assert rst asynchronously mid-cycle -> rf_we drops to 0 before the next edge, wr_count=0. After release, both valid -> A is granted first.
- Counter wrap: with CW=4, perform 17 accepted writes -> wr_count reads 1.
